// File: rtl/mmio_uart_io_if.sv
// Load/store bus between the core's I/O decode and the UART/counter block.
interface mmio_uart_io_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              io_sel;
   logic [ADDR_W-1:0] addr;
   logic              rd_en;
   logic [3:0]        wr_en;
   logic [31:0]       wdata;
   logic [31:0]       rdata;

   modport master (output io_sel, addr, rd_en, wr_en, wdata, input rdata);
   modport slave  (input io_sel, addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/mmio_uart_io.sv
// Memory-mapped UART RX/TX FIFOs plus cycle and instruction counters,
// with registered load data (one-cycle read latency).
module mmio_uart_io #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned RX_DEPTH = 8,
   parameter int unsigned TX_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mmio_uart_io_if.slave        bus,
   input  logic [7:0]           rx_data_in,
   input  logic                 rx_valid_in,
   output logic                 rx_ready_out,
   output logic [7:0]           tx_data_out,
   output logic                 tx_valid_out,
   input  logic                 tx_ready_in,
   input  logic                 inst_retire
);
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned RX_CW = RX_AW + 1;
   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned TX_CW = TX_AW + 1;

   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_CYCLE  = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_INST   = ADDR_W'(8'h14);
   localparam logic [ADDR_W-1:0] A_CNTCLR = ADDR_W'(8'h18);
   localparam logic [ADDR_W-1:0] A_OVFCLR = ADDR_W'(8'h1C);

   localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
   localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

   logic [7:0]        rx_mem [RX_DEPTH];
   logic [7:0]        tx_mem [TX_DEPTH];
   logic [RX_AW-1:0]  rx_rptr, rx_wptr;
   logic [TX_AW-1:0]  tx_rptr, tx_wptr;
   logic [RX_CW-1:0]  rx_cnt, rx_cnt_nxt;
   logic [TX_CW-1:0]  tx_cnt, tx_cnt_nxt;
   logic              rx_ovf;
   logic [CNT_W-1:0]  cyc_cnt, inst_cnt;

   logic [ADDR_W-1:0] off;
   logic              rd, wr;
   logic              rx_pop, rx_push, rx_ovf_set;
   logic              tx_pop, tx_push;
   logic              cnt_clr, ovf_clr;
   logic [31:0]       rd_val;

   assign rx_ready_out = 1'b1;
   assign tx_data_out  = tx_mem[tx_rptr];
   assign off          = bus.addr & ~ADDR_W'(3);

   // Access decode, FIFO push/pop qualification and load-data mux.
   always_comb begin
      rd         = bus.io_sel & bus.rd_en;
      wr         = bus.io_sel & (|bus.wr_en);
      rx_pop     = rd && (off == A_RXDATA) && (rx_cnt != '0);
      rx_push    = rx_valid_in && ((rx_cnt != RX_FULL) || rx_pop);
      rx_ovf_set = rx_valid_in && (rx_cnt == RX_FULL) && !rx_pop;
      tx_pop     = tx_valid_out && tx_ready_in;
      tx_push    = wr && (off == A_TXDATA) && ((tx_cnt != TX_FULL) || tx_pop);
      cnt_clr    = wr && (off == A_CNTCLR);
      ovf_clr    = wr && (off == A_OVFCLR);

      rx_cnt_nxt = rx_cnt;
      if (rx_push && !rx_pop)      rx_cnt_nxt = rx_cnt + RX_CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_nxt = rx_cnt - RX_CW'(1);

      tx_cnt_nxt = tx_cnt;
      if (tx_push && !tx_pop)      tx_cnt_nxt = tx_cnt + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_nxt = tx_cnt - TX_CW'(1);

      rd_val = '0;
      if (rd) begin
         case (off)
            A_STATUS: rd_val = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 5'b0, rx_ovf,
                                (rx_cnt != '0), (tx_cnt != TX_FULL)};
            A_RXDATA: rd_val = rx_pop ? {24'h0, rx_mem[rx_rptr]} : 32'h0;
            A_CYCLE:  rd_val = 32'(cyc_cnt);
            A_INST:   rd_val = 32'(inst_cnt);
            default:  rd_val = '0;
         endcase
      end
   end

   // Control state; storage arrays are written separately and need no reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_rptr      <= '0;
         rx_wptr      <= '0;
         rx_cnt       <= '0;
         tx_rptr      <= '0;
         tx_wptr      <= '0;
         tx_cnt       <= '0;
         tx_valid_out <= 1'b0;
         rx_ovf       <= 1'b0;
         cyc_cnt      <= '0;
         inst_cnt     <= '0;
         bus.rdata    <= '0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
         if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
         if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
         rx_cnt       <= rx_cnt_nxt;
         tx_cnt       <= tx_cnt_nxt;
         tx_valid_out <= (tx_cnt_nxt != '0);
         // Overflow set wins over a same-cycle clear.
         if (rx_ovf_set)   rx_ovf <= 1'b1;
         else if (ovf_clr) rx_ovf <= 1'b0;
         cyc_cnt   <= cnt_clr ? '0 : cyc_cnt + CNT_W'(1);
         inst_cnt  <= cnt_clr ? '0 : (inst_retire ? inst_cnt + CNT_W'(1) : inst_cnt);
         bus.rdata <= rd_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr] <= rx_data_in;
      if (tx_push) tx_mem[tx_wptr] <= bus.wdata[7:0];
   end
endmodule

// File: tb/tb_mmio_uart_io.sv
// Directed self-checking bench for mmio_uart_io (default config plus a
// CNT_W=4 instance for counter wrap).
module tb_mmio_uart_io;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       retire;
   logic       rx_ready4, tx_valid4;
   logic [7:0] tx_data4;

   int n_cmp = 0;
   int n_err = 0;

   mmio_uart_io_if #(.ADDR_W(8)) bus  ();
   mmio_uart_io_if #(.ADDR_W(8)) bus4 ();

   mmio_uart_io dut (
      .clk(clk), .rst(rst), .bus(bus),
      .rx_data_in(rx_data), .rx_valid_in(rx_valid), .rx_ready_out(rx_ready),
      .tx_data_out(tx_data), .tx_valid_out(tx_valid), .tx_ready_in(tx_ready),
      .inst_retire(retire)
   );

   mmio_uart_io #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4),
      .rx_data_in(8'h00), .rx_valid_in(1'b0), .rx_ready_out(rx_ready4),
      .tx_data_out(tx_data4), .tx_valid_out(tx_valid4), .tx_ready_in(1'b0),
      .inst_retire(1'b0)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus.io_sel = 1'b1; bus.rd_en = 1'b1; bus.addr = a;
      tick;
      bus.io_sel = 1'b0; bus.rd_en = 1'b0;
      check(tag, bus.rdata, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.io_sel = 1'b1; bus.wr_en = 4'hF; bus.addr = a; bus.wdata = d;
      tick;
      bus.io_sel = 1'b0; bus.wr_en = 4'h0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      tick;
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_b;
      rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; retire = 1'b0;
      bus.io_sel = 0;  bus.addr = '0;  bus.rd_en = 0;  bus.wr_en = '0;  bus.wdata = '0;
      bus4.io_sel = 0; bus4.addr = '0; bus4.rd_en = 0; bus4.wr_en = '0; bus4.wdata = '0;
      tick; tick;
      check("reset_rdata", bus.rdata, 32'h0);
      check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("rx_ready_const", {30'b0, rx_ready, rx_ready4}, 32'h3);
      rst = 1'b0;

      // 17 increments on a 4-bit counter wrap to 1
      repeat (17) tick;
      bus4.io_sel = 1'b1; bus4.rd_en = 1'b1; bus4.addr = 8'h10;
      tick;
      bus4.io_sel = 1'b0; bus4.rd_en = 1'b0;
      check("cnt4_wrap", bus4.rdata, 32'h1);
      check("dut4_tx_idle", {23'b0, tx_valid4, tx_data4}, 32'h0);

      rd_chk("status_reset", 8'h00, 32'h0000_0001);
      rd_chk("rx_empty_read", 8'h04, 32'h0);
      check("tx_valid_idle", {31'b0, tx_valid}, 32'h0);
      tick;
      check("rdata_idle_zero", bus.rdata, 32'h0);
      bus.rd_en = 1'b1; bus.addr = 8'h00;
      tick;
      bus.rd_en = 1'b0;
      check("no_io_sel_read", bus.rdata, 32'h0);
      rd_chk("unmapped_read", 8'h20, 32'h0);
      rd_chk("wronly_read", 8'h08, 32'h0);
      rd_chk("low_addr_bits_ignored", 8'h03, 32'h0000_0001);

      rx_push(8'hA5);
      rx_push(8'h3C);
      rd_chk("status_rx2", 8'h00, 32'h0000_0203);
      rd_chk("rx_pop_a5", 8'h04, 32'h0000_00A5);
      rd_chk("rx_pop_3c", 8'h04, 32'h0000_003C);
      rd_chk("status_rx0", 8'h00, 32'h0000_0001);

      // Fill RX with 0x01..0x08; 0x09 overflows
      for (int i = 1; i <= 9; i++) rx_push(8'(i));
      rd_chk("status_rx_ovf", 8'h00, 32'h0000_0807);
      wr(8'h1C, 32'h0);
      rd_chk("status_ovf_clr", 8'h00, 32'h0000_0803);
      rx_valid = 1'b1; rx_data = 8'h99;
      rd_chk("full_push_pop", 8'h04, 32'h0000_0001);
      rx_valid = 1'b0;
      rd_chk("status_full_pp", 8'h00, 32'h0000_0803);
      for (int i = 0; i < 8; i++) begin
         exp_b = (i == 7) ? 8'h99 : 8'(i + 2);
         rd_chk($sformatf("rx_order_%0d", i), 8'h04, {24'h0, exp_b});
      end

      // TX: fill, overflow drop, then drain in order
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(8'h08, {24'hFFFFFF, 8'(8'h11 + i)});
      rd_chk("status_tx_full", 8'h00, 32'h0008_0000);
      wr(8'h08, 32'h0000_0019);
      rd_chk("status_tx_drop", 8'h00, 32'h0008_0000);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tx_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
         check($sformatf("tx_data_%0d", i), {24'h0, tx_data}, {24'h0, 8'(8'h11 + i)});
         tick;
      end
      check("tx_drained", {31'b0, tx_valid}, 32'h0);
      rd_chk("status_tx_empty", 8'h00, 32'h0000_0001);

      // Counters
      wr(8'h18, 32'h0);
      rd_chk("cycle_after_clr", 8'h10, 32'h0);
      rd_chk("inst_after_clr", 8'h14, 32'h0);
      rd_chk("cycle_runs", 8'h10, 32'h2);
      wr(8'h18, 32'hDEAD_BEEF);
      retire = 1'b1;
      repeat (5) tick;
      retire = 1'b0;
      rd_chk("inst_5", 8'h14, 32'h5);

      // Reset mid-drain
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(8'h08, 32'(8'h40 + i));
      tx_ready = 1'b1;
      tick;
      check("tx_mid_drain", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h41});
      rst = 1'b1;
      #1;
      check("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      tick;
      rst = 1'b0;
      tx_ready = 1'b0;
      rd_chk("status_post_rst", 8'h00, 32'h0000_0001);
      rd_chk("rx_post_rst", 8'h04, 32'h0);
      rd_chk("inst_post_rst", 8'h14, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
